// File: rtl/vga_layer_compositor.sv
// ---------------------------------------------------------------------------
// vga_layer_compositor
//
// Pipelined per-pixel compositor between the VGA timing generator and the
// DAC output register.
//
// Build option: define VGA_COMP_BLINK_EN to enable the sprite-0
// invulnerability blink. When it is undefined, hit_pulse is ignored and
// sprite 0 is always eligible.
//
// Image composition
//   - NUM_SPR solid-colour sprite layers are drawn over a ROM background.
//   - Index 0 has the highest priority.
//   - Sprite attributes are latched on frame_start, so a frame never tears.
//
// Mode-change fade
//   - A change of game mode runs a frame-counted fade-out, then a fade-in.
//   - The new mode is latched at the darkest point of the fade.
//
// Ports
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   pix_x/pix_y         current pixel coordinates
//   pix_valid           pixel lies in the active region
//   frame_start         1-clk pulse ahead of each frame
//   gamemode            requested mode (00 start, 01 play, 10 pause, 11 over)
//   spr_en/x/y/w/h/rgb  flattened per-sprite attributes (sprite i at slice i)
//   hit_pulse           player hit event (blink build only)
//   bg_rgb              background ROM data, ROM_LAT clocks after its pixel
//   rgb/rgb_valid       composited colour, ROM_LAT+2 clocks after the pixel
//   shown_mode          mode currently rendered
//   fade_busy           fade transition in progress
// ---------------------------------------------------------------------------
module vga_layer_compositor #(
    parameter int NUM_SPR   = 10,
    parameter int ROM_LAT   = 1,
    parameter int FADE_STEP = 1,
    parameter int BLINK_FR  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [9:0]            pix_x,
    input  logic [8:0]            pix_y,
    input  logic                  pix_valid,
    input  logic                  frame_start,
    input  logic [1:0]            gamemode,
    input  logic [NUM_SPR-1:0]    spr_en,
    input  logic [NUM_SPR*10-1:0] spr_x,
    input  logic [NUM_SPR*9-1:0]  spr_y,
    input  logic [NUM_SPR*10-1:0] spr_w,
    input  logic [NUM_SPR*9-1:0]  spr_h,
    input  logic [NUM_SPR*12-1:0] spr_rgb,
    input  logic                  hit_pulse,
    input  logic [11:0]           bg_rgb,
    output logic [11:0]           rgb,
    output logic                  rgb_valid,
    output logic [1:0]            shown_mode,
    output logic                  fade_busy
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FADE_OUT = 2'd1,
        ST_FADE_IN  = 2'd2
    } state_t;

    localparam logic [4:0] STEP5 = 5'(FADE_STEP);

    // Subtract the fade level from each 4-bit channel, saturating at zero.
    function automatic logic [11:0] fade_rgb(input logic [11:0] c, input logic [3:0] lvl);
        logic [11:0] r;
        r = 12'h000;
        for (int k = 0; k < 3; k++) begin
            r[k*4 +: 4] = (c[k*4 +: 4] > lvl) ? (c[k*4 +: 4] - lvl) : 4'h0;
        end
        return r;
    endfunction

    // Shadow copies of the sprite attributes.
    logic [NUM_SPR-1:0]    sh_en_r;
    logic [NUM_SPR*10-1:0] sh_x_r;
    logic [NUM_SPR*9-1:0]  sh_y_r;
    logic [NUM_SPR*10-1:0] sh_w_r;
    logic [NUM_SPR*9-1:0]  sh_h_r;
    logic [NUM_SPR*12-1:0] sh_rgb_r;

    // Fade state.
    state_t      state_r;
    logic [3:0]  level_r;
    logic [1:0]  shown_mode_r;
    logic        fade_busy_r;
    logic [3:0]  level_up_s;
    logic [3:0]  level_dn_s;
    logic [4:0]  level_sum_s;

    // Hit test and pipeline.
    logic [NUM_SPR-1:0]         elig_s;
    logic [NUM_SPR-1:0]         spr_hit_s;
    logic                       hit_s;
    logic [11:0]                hit_col_s;
    logic                       sprites_on_s;
    logic                       spr0_ok_s;
    logic [ROM_LAT-1:0]         hit_pipe_r;
    logic [ROM_LAT-1:0]         vld_pipe_r;
    logic [ROM_LAT-1:0][11:0]   col_pipe_r;
    logic                       mux_vld_r;
    logic [11:0]                mux_rgb_r;
    logic                       rgb_valid_r;
    logic [11:0]                rgb_r;

`ifdef VGA_COMP_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_FR + 1);
    logic [BLINK_W-1:0] blink_cnt_r;

    // Blink counter: a hit (re)loads it and wins over the frame decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_r <= {BLINK_W{1'b0}};
        end else if (hit_pulse) begin
            blink_cnt_r <= BLINK_W'(BLINK_FR);
        end else if (frame_start && (blink_cnt_r != {BLINK_W{1'b0}})) begin
            blink_cnt_r <= blink_cnt_r - BLINK_W'(1);
        end
    end

    assign spr0_ok_s = ~blink_cnt_r[0];
`else
    logic unused_s;
    assign unused_s  = hit_pulse;
    assign spr0_ok_s = 1'b1;
`endif

    // Sprites are hidden entirely while the start screen is shown.
    assign sprites_on_s = (shown_mode_r != 2'b00);

    // Per-sprite hit test. Ends are widened by one bit so a sprite clips at the edge.
    for (genvar g = 0; g < NUM_SPR; g++) begin : g_hit
        logic [10:0] x_end_s;
        logic [9:0]  y_end_s;
        logic        in_x_s;
        logic        in_y_s;
        assign x_end_s = {1'b0, sh_x_r[g*10 +: 10]} + {1'b0, sh_w_r[g*10 +: 10]};
        assign y_end_s = {1'b0, sh_y_r[g*9 +: 9]} + {1'b0, sh_h_r[g*9 +: 9]};
        assign in_x_s  = (pix_x >= sh_x_r[g*10 +: 10]) && ({1'b0, pix_x} < x_end_s);
        assign in_y_s  = (pix_y >= sh_y_r[g*9 +: 9]) && ({1'b0, pix_y} < y_end_s);
        assign elig_s[g]    = (g == 0) ? spr0_ok_s : 1'b1;
        assign spr_hit_s[g] = sh_en_r[g] & in_x_s & in_y_s & elig_s[g] & sprites_on_s;
    end

    // Priority select: walk from the highest index down so the lowest index wins.
    always_comb begin
        hit_s     = 1'b0;
        hit_col_s = 12'h000;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (spr_hit_s[i]) begin
                hit_s     = 1'b1;
                hit_col_s = sh_rgb_r[i*12 +: 12];
            end else begin
                hit_s     = hit_s;
                hit_col_s = hit_col_s;
            end
        end
    end

    // Saturating next fade levels in both directions.
    always_comb begin
        level_sum_s = {1'b0, level_r} + STEP5;
        if (level_sum_s > 5'd15) begin
            level_up_s = 4'hF;
        end else begin
            level_up_s = level_sum_s[3:0];
        end
        if ({1'b0, level_r} > STEP5) begin
            level_dn_s = level_r - STEP5[3:0];
        end else begin
            level_dn_s = 4'h0;
        end
    end

    // Latch sprite attributes once per frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_en_r  <= {NUM_SPR{1'b0}};
            sh_x_r   <= {NUM_SPR*10{1'b0}};
            sh_y_r   <= {NUM_SPR*9{1'b0}};
            sh_w_r   <= {NUM_SPR*10{1'b0}};
            sh_h_r   <= {NUM_SPR*9{1'b0}};
            sh_rgb_r <= {NUM_SPR*12{1'b0}};
        end else if (frame_start) begin
            sh_en_r  <= spr_en;
            sh_x_r   <= spr_x;
            sh_y_r   <= spr_y;
            sh_w_r   <= spr_w;
            sh_h_r   <= spr_h;
            sh_rgb_r <= spr_rgb;
        end
    end

    // Fade FSM: the mode is swapped only at the darkest level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            level_r      <= 4'h0;
            shown_mode_r <= 2'b00;
            fade_busy_r  <= 1'b0;
        end else if (frame_start) begin
            case (state_r)
                ST_IDLE: begin
                    if (gamemode != shown_mode_r) begin
                        state_r     <= ST_FADE_OUT;
                        fade_busy_r <= 1'b1;
                    end
                end
                ST_FADE_OUT: begin
                    if (level_r == 4'hF) begin
                        shown_mode_r <= gamemode;
                        state_r      <= ST_FADE_IN;
                    end else begin
                        level_r <= level_up_s;
                    end
                end
                ST_FADE_IN: begin
                    if (level_r == 4'h0) begin
                        state_r     <= ST_IDLE;
                        fade_busy_r <= 1'b0;
                    end else begin
                        level_r <= level_dn_s;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    level_r     <= 4'h0;
                    fade_busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Delay the hit result, colour and valid to line up with the ROM data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_pipe_r <= {ROM_LAT{1'b0}};
            vld_pipe_r <= {ROM_LAT{1'b0}};
            col_pipe_r <= {ROM_LAT*12{1'b0}};
        end else begin
            hit_pipe_r[0] <= hit_s;
            vld_pipe_r[0] <= pix_valid;
            col_pipe_r[0] <= hit_col_s;
            for (int i = 1; i < ROM_LAT; i++) begin
                hit_pipe_r[i] <= hit_pipe_r[i-1];
                vld_pipe_r[i] <= vld_pipe_r[i-1];
                col_pipe_r[i] <= col_pipe_r[i-1];
            end
        end
    end

    // Layer mux stage, followed by the fade into the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_vld_r   <= 1'b0;
            mux_rgb_r   <= 12'h000;
            rgb_valid_r <= 1'b0;
            rgb_r       <= 12'h000;
        end else begin
            mux_vld_r   <= vld_pipe_r[ROM_LAT-1];
            mux_rgb_r   <= !vld_pipe_r[ROM_LAT-1] ? 12'h000 :
                           (hit_pipe_r[ROM_LAT-1] ? col_pipe_r[ROM_LAT-1] : bg_rgb);
            rgb_valid_r <= mux_vld_r;
            rgb_r       <= mux_vld_r ? fade_rgb(mux_rgb_r, level_r) : 12'h000;
        end
    end

    assign rgb        = rgb_r;
    assign rgb_valid  = rgb_valid_r;
    assign shown_mode = shown_mode_r;
    assign fade_busy  = fade_busy_r;

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Directed testbench for vga_layer_compositor (default parameters).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_vga_layer_compositor;

    localparam int NS = 10;

    logic            clk;
    logic            rst_n;
    logic [9:0]      pix_x;
    logic [8:0]      pix_y;
    logic            pix_valid;
    logic            frame_start;
    logic [1:0]      gamemode;
    logic [NS-1:0]   spr_en;
    logic [NS*10-1:0] spr_x;
    logic [NS*9-1:0] spr_y;
    logic [NS*10-1:0] spr_w;
    logic [NS*9-1:0] spr_h;
    logic [NS*12-1:0] spr_rgb;
    logic            hit_pulse;
    logic [11:0]     bg_rgb;
    logic [11:0]     rgb;
    logic            rgb_valid;
    logic [1:0]      shown_mode;
    logic            fade_busy;

    logic [11:0]     bg_const;
    logic            bg_pat;
    int              total;
    int              bad;

    vga_layer_compositor dut (
        .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
        .pix_valid(pix_valid), .frame_start(frame_start), .gamemode(gamemode),
        .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y), .spr_w(spr_w),
        .spr_h(spr_h), .spr_rgb(spr_rgb), .hit_pulse(hit_pulse),
        .bg_rgb(bg_rgb), .rgb(rgb), .rgb_valid(rgb_valid),
        .shown_mode(shown_mode), .fade_busy(fade_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Background ROM model with one clock of read latency.
    always @(posedge clk) bg_rgb <= bg_pat ? {2'b00, pix_x} : bg_const;

    task automatic set_spr(input int i, input logic [9:0] x, input logic [8:0] y,
                           input logic [9:0] w, input logic [8:0] h, input logic [11:0] c);
        spr_x[i*10 +: 10]  = x;
        spr_y[i*9 +: 9]    = y;
        spr_w[i*10 +: 10]  = w;
        spr_h[i*9 +: 9]    = h;
        spr_rgb[i*12 +: 12] = c;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // One isolated valid pixel; returns the output three clocks later.
    task automatic probe(input logic [9:0] x, input logic [8:0] y,
                         output logic [11:0] got, output logic gv);
        pix_x = x; pix_y = y; pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        got = rgb; gv = rgb_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pix_valid = 1'b1;
        repeat (3) @(negedge clk);
        total += 4;
        if (rgb !== 12'h000) begin bad++; $display("FAIL reset_rgb got=%h want=000", rgb); end
        if (rgb_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", rgb_valid); end
        if (shown_mode !== 2'b00) begin bad++; $display("FAIL reset_mode got=%b want=00", shown_mode); end
        if (fade_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", fade_busy); end
        pix_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_background();
        logic v1, v2, v3, v4;
        logic [11:0] r3, r4;
        bg_const = 12'h5A3; bg_pat = 1'b0;
        pix_x = 10'd10; pix_y = 9'd10; pix_valid = 1'b1;
        @(negedge clk); v1 = rgb_valid; pix_valid = 1'b0;
        @(negedge clk); v2 = rgb_valid;
        @(negedge clk); v3 = rgb_valid; r3 = rgb;
        @(negedge clk); v4 = rgb_valid; r4 = rgb;
        total += 6;
        if (v1 !== 1'b0) begin bad++; $display("FAIL bg_valid_lat1 got=%b want=0", v1); end
        if (v2 !== 1'b0) begin bad++; $display("FAIL bg_valid_lat2 got=%b want=0", v2); end
        if (v3 !== 1'b1) begin bad++; $display("FAIL bg_valid_lat3 got=%b want=1", v3); end
        if (r3 !== 12'h5A3) begin bad++; $display("FAIL bg_rgb_lat3 got=%h want=5a3", r3); end
        if (v4 !== 1'b0) begin bad++; $display("FAIL bg_valid_lat4 got=%b want=0", v4); end
        if (r4 !== 12'h000) begin bad++; $display("FAIL bg_rgb_invalid got=%h want=000", r4); end
    endtask

    task automatic test_mode00_suppress();
        logic [11:0] g; logic gv;
        bg_const = 12'h123;
        set_spr(0, 10'd160, 9'd100, 10'd40, 9'd40, 12'h00F);
        set_spr(3, 10'd160, 9'd100, 10'd40, 9'd40, 12'hFA0);
        spr_en = 10'b00_0000_1001;
        frame();
        probe(10'd170, 9'd110, g, gv);
        total++;
        if (g !== 12'h123) begin bad++; $display("FAIL mode00_suppress got=%h want=123", g); end
    endtask

    task automatic test_mode_switch();
        int n;
        logic busy_first;
        gamemode = 2'b01;
        n = 0;
        busy_first = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            frame();
            n = k;
            if (k == 1) busy_first = fade_busy;
            if (k > 1 && fade_busy == 1'b0) break;
        end
        total += 4;
        if (busy_first !== 1'b1) begin bad++; $display("FAIL switch_busy_rise got=%b want=1", busy_first); end
        if (n != 33) begin bad++; $display("FAIL switch_frames got=%0d want=33", n); end
        if (fade_busy !== 1'b0) begin bad++; $display("FAIL switch_busy_end got=%b want=0", fade_busy); end
        if (shown_mode !== 2'b01) begin bad++; $display("FAIL switch_mode got=%b want=01", shown_mode); end
    endtask

    task automatic test_priority();
        logic [11:0] g; logic gv;
        probe(10'd170, 9'd110, g, gv);
        total += 2;
        if (g !== 12'h00F) begin bad++; $display("FAIL prio_both got=%h want=00f", g); end
        if (gv !== 1'b1) begin bad++; $display("FAIL prio_valid got=%b want=1", gv); end
        spr_en = 10'b00_0000_1000;
        frame();
        probe(10'd170, 9'd110, g, gv);
        total++;
        if (g !== 12'hFA0) begin bad++; $display("FAIL prio_spr3 got=%h want=fa0", g); end
        probe(10'd199, 9'd139, g, gv);
        total++;
        if (g !== 12'hFA0) begin bad++; $display("FAIL prio_corner got=%h want=fa0", g); end
        probe(10'd200, 9'd110, g, gv);
        total++;
        if (g !== 12'h123) begin bad++; $display("FAIL prio_right_edge got=%h want=123", g); end
        probe(10'd170, 9'd140, g, gv);
        total++;
        if (g !== 12'h123) begin bad++; $display("FAIL prio_bottom_edge got=%h want=123", g); end
        probe(10'd159, 9'd110, g, gv);
        total++;
        if (g !== 12'h123) begin bad++; $display("FAIL prio_left_edge got=%h want=123", g); end
        spr_en = 10'b00_0000_1001;
        frame();
    endtask

    task automatic test_shadow();
        logic [11:0] g; logic gv;
        spr_x[9:0] = 10'd300;
        probe(10'd165, 9'd110, g, gv);
        total++;
        if (g !== 12'h00F) begin bad++; $display("FAIL shadow_old_pos got=%h want=00f", g); end
        probe(10'd305, 9'd110, g, gv);
        total++;
        if (g !== 12'h123) begin bad++; $display("FAIL shadow_new_pos_early got=%h want=123", g); end
        frame();
        probe(10'd165, 9'd110, g, gv);
        total++;
        if (g !== 12'hFA0) begin bad++; $display("FAIL shadow_old_pos_after got=%h want=fa0", g); end
        probe(10'd305, 9'd110, g, gv);
        total++;
        if (g !== 12'h00F) begin bad++; $display("FAIL shadow_new_pos_after got=%h want=00f", g); end
    endtask

    task automatic test_clip();
        logic [11:0] g; logic gv;
        set_spr(1, 10'd630, 9'd200, 10'd30, 9'd10, 12'h0F0);
        set_spr(2, 10'd630, 9'd300, 10'd500, 9'd5, 12'hF00);
        spr_en = 10'b00_0000_0110;
        frame();
        probe(10'd630, 9'd200, g, gv);
        total++;
        if (g !== 12'h0F0) begin bad++; $display("FAIL clip_first got=%h want=0f0", g); end
        probe(10'd639, 9'd200, g, gv);
        total++;
        if (g !== 12'h0F0) begin bad++; $display("FAIL clip_last got=%h want=0f0", g); end
        probe(10'd629, 9'd200, g, gv);
        total++;
        if (g !== 12'h123) begin bad++; $display("FAIL clip_before got=%h want=123", g); end
        probe(10'd0, 9'd201, g, gv);
        total++;
        if (g !== 12'h123) begin bad++; $display("FAIL clip_nowrap_x0 got=%h want=123", g); end
        probe(10'd19, 9'd201, g, gv);
        total++;
        if (g !== 12'h123) begin bad++; $display("FAIL clip_nowrap_x19 got=%h want=123", g); end
        probe(10'd635, 9'd300, g, gv);
        total++;
        if (g !== 12'hF00) begin bad++; $display("FAIL clip_wide_sum got=%h want=f00", g); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_q [8];
        logic [9:0] x;
        spr_x[9:0] = 10'd160;
        spr_en = 10'b00_0000_0001;
        frame();
        bg_pat = 1'b1;
        for (int j = 0; j < 8; j++) begin
            x = 10'(196 + j);
            exp_q[j] = (x < 10'd200) ? 12'h00F : {2'b00, x};
        end
        for (int i = 0; i < 11; i++) begin
            if (i >= 3) begin
                total += 2;
                if (rgb !== exp_q[i-3]) begin
                    bad++; $display("FAIL stream_rgb idx=%0d got=%h want=%h", i - 3, rgb, exp_q[i-3]);
                end
                if (rgb_valid !== 1'b1) begin
                    bad++; $display("FAIL stream_valid idx=%0d got=%b want=1", i - 3, rgb_valid);
                end
            end
            if (i < 8) begin
                pix_x = 10'(196 + i); pix_y = 9'd110; pix_valid = 1'b1;
            end else begin
                pix_valid = 1'b0;
            end
            @(negedge clk);
        end
        total++;
        if (rgb_valid !== 1'b0) begin bad++; $display("FAIL stream_tail_valid got=%b want=0", rgb_valid); end
        bg_pat = 1'b0;
    endtask

    task automatic test_blink();
        logic [11:0] g, want; logic gv;
        logic hidden;
        hit_pulse = 1'b1;
        @(negedge clk);
        hit_pulse = 1'b0;
        probe(10'd170, 9'd110, g, gv);
        total++;
        if (g !== 12'h00F) begin bad++; $display("FAIL blink_k0 got=%h want=00f", g); end
        for (int k = 1; k <= 10; k++) begin
            frame();
            probe(10'd170, 9'd110, g, gv);
`ifdef VGA_COMP_BLINK_EN
            hidden = (k <= 8) && (((8 - k) % 2) == 1);
`else
            hidden = 1'b0;
`endif
            want = hidden ? 12'h123 : 12'h00F;
            total++;
            if (g !== want) begin bad++; $display("FAIL blink_frame k=%0d got=%h want=%h", k, g, want); end
        end
    endtask

    task automatic test_fade();
        logic [11:0] g, want; logic gv;
        int lvl;
        logic [3:0] ch;
        spr_en = 10'b00_0000_0000;
        frame();
        bg_const = 12'hFFF;
        gamemode = 2'b11;
        for (int k = 1; k <= 33; k++) begin
            frame();
            probe(10'd5, 9'd5, g, gv);
            if (k == 1) lvl = 0;
            else if (k <= 16) lvl = k - 1;
            else if (k == 17) lvl = 15;
            else if (k <= 32) lvl = 32 - k;
            else lvl = 0;
            ch = 4'(15 - lvl);
            want = {ch, ch, ch};
            total += 3;
            if (g !== want) begin bad++; $display("FAIL fade_rgb k=%0d got=%h want=%h", k, g, want); end
            if (shown_mode !== ((k >= 17) ? 2'b11 : 2'b01)) begin
                bad++; $display("FAIL fade_mode k=%0d got=%b want=%b", k, shown_mode, (k >= 17) ? 2'b11 : 2'b01);
            end
            if (fade_busy !== (k < 33)) begin
                bad++; $display("FAIL fade_busy k=%0d got=%b want=%b", k, fade_busy, (k < 33));
            end
        end
    endtask

    task automatic test_reset_mid_fade();
        gamemode = 2'b01;
        repeat (5) frame();
        pix_x = 10'd5; pix_y = 9'd5; pix_valid = 1'b1;
        repeat (3) @(negedge clk);
        total += 2;
        if (rgb !== 12'hBBB) begin bad++; $display("FAIL midfade_level got=%h want=bbb", rgb); end
        if (fade_busy !== 1'b1) begin bad++; $display("FAIL midfade_busy got=%b want=1", fade_busy); end
        #2 rst_n = 1'b0;
        #1;
        total += 4;
        if (rgb !== 12'h000) begin bad++; $display("FAIL arst_rgb got=%h want=000", rgb); end
        if (rgb_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b want=0", rgb_valid); end
        if (shown_mode !== 2'b00) begin bad++; $display("FAIL arst_mode got=%b want=00", shown_mode); end
        if (fade_busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b want=0", fade_busy); end
        pix_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; pix_x = 10'd0; pix_y = 9'd0; pix_valid = 1'b0;
        frame_start = 1'b0; gamemode = 2'b00; hit_pulse = 1'b0;
        spr_en = '0; spr_x = '0; spr_y = '0; spr_w = '0; spr_h = '0; spr_rgb = '0;
        bg_const = 12'h000; bg_pat = 1'b0;
        @(negedge clk);
        test_reset();
        test_background();
        test_mode00_suppress();
        test_mode_switch();
        test_priority();
        test_shadow();
        test_clip();
        test_back_to_back();
        test_blink();
        test_fade();
        test_reset_mid_fade();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
